// File: rtl/fp_mul_seq.sv
// Multi-cycle IEEE-754 multiplier. The format is set by EXP_W/MAN_W, and the significand
// product uses an iterative shift-add. Rounding is RNE or RTZ, and subnormals flush to zero.
module fp_mul_seq #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [EXP_W+MAN_W:0]   op_a,
   input  logic [EXP_W+MAN_W:0]   op_b,
   input  logic                   round_mode,
   output logic                   busy,
   output logic                   valid_out,
   output logic [EXP_W+MAN_W:0]   result,
   output logic [4:0]             flags
);
   localparam int W  = EXP_W + MAN_W + 1;
   localparam int N  = MAN_W + 1;
   localparam int P  = 2 * N;
   localparam int EW = EXP_W + 2;
   localparam int CW = $clog2(N + 1);
   localparam logic signed [EW-1:0] BIAS_S   = EW'(2**(EXP_W-1) - 1);
   localparam logic signed [EW-1:0] EXP_ONE  = EW'(1);
   localparam logic signed [EW-1:0] EXP_MAX  = EW'(2**EXP_W - 1);
   localparam logic signed [EW-1:0] EXP_ZERO = '0;
   localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

   typedef enum logic [2:0] {IDLE, UNPACK, MULT, NORM, ROUND, DONE} state_t;

   state_t                 state_q;
   logic [W-1:0]           a_q, b_q, result_q;
   logic                   rm_q, sign_q, busy_q, valid_q;
   logic [4:0]             flags_q;
   logic signed [EW-1:0]   exp_q;
   logic [N-1:0]           mcand_q;
   logic [P-1:0]           prod_q;
   logic [CW-1:0]          cnt_q;
   logic [MAN_W-1:0]       frac_q;
   logic                   g_q, r_q, s_q;

   // Operand classification, taken from the latched copies
   logic [EXP_W-1:0] ea, eb;
   logic [MAN_W-1:0] fa, fb;
   logic a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero, s_x, special;
   logic signed [EW-1:0] exp_sum;

   assign ea     = a_q[W-2:MAN_W];
   assign eb     = b_q[W-2:MAN_W];
   assign fa     = a_q[MAN_W-1:0];
   assign fb     = b_q[MAN_W-1:0];
   assign s_x    = a_q[W-1] ^ b_q[W-1];
   assign a_nan  = (&ea) && (|fa);
   assign b_nan  = (&eb) && (|fb);
   assign a_snan = a_nan && !fa[MAN_W-1];
   assign b_snan = b_nan && !fb[MAN_W-1];
   assign a_inf  = (&ea) && !(|fa);
   assign b_inf  = (&eb) && !(|fb);
   assign a_zero = (ea == '0);
   assign b_zero = (eb == '0);
   assign special = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;
   assign exp_sum = $signed(EW'(ea)) + $signed(EW'(eb)) - BIAS_S;

   logic [W-1:0] spec_res;
   logic [4:0]   spec_flg;

   always_comb begin
      spec_res = {s_x, {(W-1){1'b0}}};
      spec_flg = '0;
      if (a_nan || b_nan) begin
         spec_res    = QNAN;
         spec_flg[4] = a_snan | b_snan;
      end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
         spec_res    = QNAN;
         spec_flg[4] = 1'b1;
      end else if (a_inf || b_inf) begin
         spec_res = {s_x, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end
   end

   // One shift-add step: upper half absorbs the multiplicand, then the whole product shifts right
   logic [N:0]   sum;
   logic [P-1:0] prod_step;

   always_comb begin
      sum       = {1'b0, prod_q[P-1:N]} + {1'b0, mcand_q};
      prod_step = prod_q[0] ? {sum, prod_q[N-1:1]} : {1'b0, prod_q[P-1:1]};
   end

   logic                 inc, carry, ovf, unf, inx;
   logic [N:0]           sig_r;
   logic [MAN_W-1:0]     frac_r;
   logic signed [EW-1:0] exp_r;
   logic [W-1:0]         rnd_res;

   always_comb begin
      inc     = !rm_q && g_q && (r_q || s_q || frac_q[0]);
      sig_r   = {2'b01, frac_q} + (N+1)'(inc);
      carry   = sig_r[N];
      frac_r  = carry ? sig_r[MAN_W:1] : sig_r[MAN_W-1:0];
      exp_r   = carry ? exp_q + EXP_ONE : exp_q;
      inx     = g_q | r_q | s_q;
      ovf     = (exp_r >= EXP_MAX);
      unf     = !ovf && (exp_r <= EXP_ZERO);
      rnd_res = {sign_q, exp_r[EXP_W-1:0], frac_r};
      if (ovf)
         rnd_res = rm_q ? {sign_q, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}}
                        : {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      else if (unf)
         rnd_res = {sign_q, {(W-1){1'b0}}};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         busy_q   <= 1'b0;
         valid_q  <= 1'b0;
         result_q <= '0;
         flags_q  <= '0;
         a_q      <= '0;
         b_q      <= '0;
         rm_q     <= 1'b0;
         sign_q   <= 1'b0;
         exp_q    <= '0;
         mcand_q  <= '0;
         prod_q   <= '0;
         cnt_q    <= '0;
         frac_q   <= '0;
         g_q      <= 1'b0;
         r_q      <= 1'b0;
         s_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (start) begin
               a_q     <= op_a;
               b_q     <= op_b;
               rm_q    <= round_mode;
               flags_q <= '0;
               busy_q  <= 1'b1;
               state_q <= UNPACK;
            end
            UNPACK: begin
               sign_q  <= s_x;
               exp_q   <= exp_sum;
               mcand_q <= {1'b1, fa};
               prod_q  <= {{N{1'b0}}, 1'b1, fb};
               cnt_q   <= '0;
               if (special) begin
                  result_q <= spec_res;
                  flags_q  <= spec_flg;
                  valid_q  <= 1'b1;
                  state_q  <= DONE;
               end else begin
                  state_q <= MULT;
               end
            end
            MULT: begin
               prod_q <= prod_step;
               cnt_q  <= cnt_q + 1'b1;
               if (cnt_q == CW'(N-1)) state_q <= NORM;
            end
            NORM: begin
               // Product lies in [1,4); a set top bit means one extra exponent step
               if (prod_q[P-1]) begin
                  exp_q  <= exp_q + EXP_ONE;
                  frac_q <= prod_q[P-2:N];
                  g_q    <= prod_q[MAN_W];
                  r_q    <= prod_q[MAN_W-1];
                  s_q    <= |prod_q[MAN_W-2:0];
               end else begin
                  frac_q <= prod_q[P-3:MAN_W];
                  g_q    <= prod_q[MAN_W-1];
                  r_q    <= prod_q[MAN_W-2];
                  s_q    <= |prod_q[MAN_W-3:0];
               end
               state_q <= ROUND;
            end
            ROUND: begin
               result_q <= rnd_res;
               flags_q  <= {1'b0, 1'b0, ovf, unf, inx | ovf | unf};
               valid_q  <= 1'b1;
               state_q  <= DONE;
            end
            DONE: if (!start) begin
               valid_q <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy      = busy_q;
   assign valid_out = valid_q;
   assign result    = result_q;
   assign flags     = flags_q;
endmodule

// File: tb/tb_fp_mul_seq.sv
// Scoreboard bench: a single-precision and a half-precision instance share clock and reset,
// and directed vectors push expectations that per-instance monitors pop on valid_out.
module tb_fp_mul_seq;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic        start_s = 1'b0, rm_s = 1'b0, busy_s, vo_s;
   logic [31:0] a_s = '0, b_s = '0, res_s;
   logic [4:0]  flg_s;
   logic        start_h = 1'b0, rm_h = 1'b0, busy_h, vo_h;
   logic [15:0] a_h = '0, b_h = '0, res_h;
   logic [4:0]  flg_h;

   fp_mul_seq #(.EXP_W(8), .MAN_W(23)) u_sp (
      .clk(clk), .rst(rst), .start(start_s), .op_a(a_s), .op_b(b_s), .round_mode(rm_s),
      .busy(busy_s), .valid_out(vo_s), .result(res_s), .flags(flg_s));
   fp_mul_seq #(.EXP_W(5), .MAN_W(10)) u_hp (
      .clk(clk), .rst(rst), .start(start_h), .op_a(a_h), .op_b(b_h), .round_mode(rm_h),
      .busy(busy_h), .valid_out(vo_h), .result(res_h), .flags(flg_h));

   always #5 clk = ~clk;

   typedef struct { logic [31:0] res; logic [4:0] flg; int lat; int t0; } exp_t;
   exp_t q_s[$], q_h[$];
   int checks = 0, errors = 0, cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   task automatic mon_pop(input bit hp, input logic [31:0] res, input logic [4:0] flg);
      exp_t e;
      if ((hp ? q_h.size() : q_s.size()) == 0) begin
         checks++; errors++;
         $display("FAIL %s unexpected valid_out: got result %h", hp ? "hp" : "sp", res);
      end else begin
         e = hp ? q_h.pop_front() : q_s.pop_front();
         chk(hp ? "hp_result" : "sp_result", res, e.res);
         chk(hp ? "hp_flags" : "sp_flags", {27'd0, flg}, {27'd0, e.flg});
         chk(hp ? "hp_latency" : "sp_latency", cyc - e.t0, e.lat);
      end
   endtask

   initial begin : mon_sp
      logic pv = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst && vo_s && !pv) mon_pop(1'b0, res_s, flg_s);
         pv = vo_s;
      end
   end

   initial begin : mon_hp
      logic pv = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst && vo_h && !pv) mon_pop(1'b1, {16'd0, res_h}, flg_h);
         pv = vo_h;
      end
   end

   // Drive one request; operands are scrambled after acceptance to show they are latched
   task automatic issue(input bit hp, input logic [31:0] a, input logic [31:0] b, input bit rm,
                        input logic [31:0] er, input logic [4:0] ef, input int lat, input bit hold);
      @(negedge clk);
      if (hp) begin
         a_h = a[15:0]; b_h = b[15:0]; rm_h = rm; start_h = 1'b1;
         q_h.push_back('{res: er, flg: ef, lat: lat, t0: cyc});
      end else begin
         a_s = a; b_s = b; rm_s = rm; start_s = 1'b1;
         q_s.push_back('{res: er, flg: ef, lat: lat, t0: cyc});
      end
      @(negedge clk);
      if (hp) begin a_h = ~a_h; b_h = ~b_h; rm_h = ~rm; if (!hold) start_h = 1'b0; end
      else    begin a_s = ~a_s; b_s = ~b_s; rm_s = ~rm; if (!hold) start_s = 1'b0; end
   endtask

   task automatic drain(input bit hp);
      for (int i = 0; i < 100 && (hp ? q_h.size() : q_s.size()) != 0; i++) @(negedge clk);
      if ((hp ? q_h.size() : q_s.size()) != 0) begin
         checks++; errors++;
         $display("FAIL %s timeout waiting for valid_out", hp ? "hp" : "sp");
         if (hp) q_h.delete(); else q_s.delete();
      end
      @(negedge clk);
   endtask

   task automatic op(input bit hp, input logic [31:0] a, input logic [31:0] b, input bit rm,
                     input logic [31:0] er, input logic [4:0] ef, input int lat);
      issue(hp, a, b, rm, er, ef, lat, 1'b0);
      drain(hp);
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_sp_busy", {31'd0, busy_s}, 32'd0);
      chk("rst_sp_valid", {31'd0, vo_s}, 32'd0);
      chk("rst_sp_result", res_s, 32'd0);
      chk("rst_sp_flags", {27'd0, flg_s}, 32'd0);
      chk("rst_hp_valid", {31'd0, vo_h}, 32'd0);
      chk("rst_hp_result", {16'd0, res_h}, 32'd0);
      rst = 1'b0;

      // Single precision: normal, special and boundary cases
      op(0, 32'h40400000, 32'h40000000, 0, 32'h40C00000, 5'b00000, 28);
      op(0, 32'hC0400000, 32'h40000000, 0, 32'hC0C00000, 5'b00000, 28);
      op(0, 32'h7F800000, 32'h00000000, 0, 32'h7FC00000, 5'b10000, 2);
      op(0, 32'h7F800001, 32'h3F800000, 0, 32'h7FC00000, 5'b10000, 2);
      op(0, 32'hFFC00000, 32'h3F800000, 0, 32'h7FC00000, 5'b00000, 2);
      op(0, 32'h7F800000, 32'hC0000000, 0, 32'hFF800000, 5'b00000, 2);
      op(0, 32'h80000000, 32'h3F800000, 0, 32'h80000000, 5'b00000, 2);
      op(0, 32'h00000001, 32'h40000000, 0, 32'h00000000, 5'b00000, 2);
      op(0, 32'h7F7FFFFF, 32'h40000000, 0, 32'h7F800000, 5'b00101, 28);
      op(0, 32'h7F7FFFFF, 32'h40000000, 1, 32'h7F7FFFFF, 5'b00101, 28);
      op(0, 32'h00800000, 32'h3F000000, 0, 32'h00000000, 5'b00011, 28);
      op(0, 32'h3F99999A, 32'h3FA66666, 0, 32'h3FC7AE15, 5'b00001, 28);
      op(0, 32'h3F99999A, 32'h3FA66666, 1, 32'h3FC7AE14, 5'b00001, 28);

      // Half precision
      op(1, 32'h4000, 32'h4200, 0, 32'h4600, 5'b00000, 15);
      op(1, 32'h7BFF, 32'h4000, 0, 32'h7C00, 5'b00101, 15);
      op(1, 32'h7BFF, 32'h4000, 1, 32'h7BFF, 5'b00101, 15);

      // Hold start through DONE, then release
      issue(0, 32'h40400000, 32'h40000000, 0, 32'h40C00000, 5'b00000, 28, 1'b1);
      for (int i = 0; i < 100 && q_s.size() != 0; i++) @(negedge clk);
      repeat (3) begin
         @(negedge clk);
         chk("hold_valid", {31'd0, vo_s}, 32'd1);
         chk("hold_result", res_s, 32'h40C00000);
      end
      start_s = 1'b0;
      @(negedge clk);
      chk("drop_valid", {31'd0, vo_s}, 32'd0);
      chk("drop_busy", {31'd0, busy_s}, 32'd0);
      chk("drop_result_held", res_s, 32'h40C00000);

      // Start pulse mid-MULT must not restart the operation
      issue(0, 32'h3F800000, 32'h3F800000, 0, 32'h3F800000, 5'b00000, 28, 1'b0);
      repeat (5) @(negedge clk);
      a_s = 32'h40000000; b_s = 32'h40000000; start_s = 1'b1;
      @(negedge clk);
      start_s = 1'b0;
      drain(0);
      repeat (40) @(negedge clk);
      chk("pulse_idle_busy", {31'd0, busy_s}, 32'd0);

      // Reset during MULT aborts; a new op afterwards completes
      @(negedge clk);
      a_s = 32'h40400000; b_s = 32'h40400000; rm_s = 1'b0; start_s = 1'b1;
      @(negedge clk);
      start_s = 1'b0;
      repeat (6) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_busy", {31'd0, busy_s}, 32'd0);
      chk("abort_valid", {31'd0, vo_s}, 32'd0);
      chk("abort_result", res_s, 32'd0);
      chk("abort_flags", {27'd0, flg_s}, 32'd0);
      rst = 1'b0;
      op(0, 32'hC0000000, 32'h40400000, 0, 32'hC0C00000, 5'b00000, 28);
      repeat (40) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
